serial_ram_reader: RTL and testbench

//  In-design read master for the external pin-serial RAM. Takes read requests over a

---
 rtl/serial_ram_pkg.sv | 17 +
 rtl/serial_ram_rsp_fifo.sv | 43 ++++
 rtl/serial_ram_reader.sv | 99 +++++++++
 tb/tb_serial_ram_reader.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/serial_ram_pkg.sv
// serial_ram_pkg: default sizing, frame derivations and latency legality check for the serial RAM reader
package serial_ram_pkg;
  localparam int DEF_ADDR_PINS = 4;
  localparam int DEF_DATA_PINS = 4;
  localparam int DEF_LOG2_CYCLES = 2;
  localparam int DEF_RX_DELAY = 12;
  localparam int DEF_FIFO_DEPTH = 4;
  function automatic int cycles_of(input int log2_cycles);
    return 1 << log2_cycles;
  endfunction
  function automatic int phase_w(input int log2_cycles);
    return log2_cycles > 0 ? log2_cycles : 1;
  endfunction
  function automatic bit rx_delay_ok(input int rx_delay, input int cycles);
    return rx_delay >= cycles + 1;
  endfunction
endpackage

// File: rtl/serial_ram_rsp_fifo.sv
// serial_ram_rsp_fifo: in-order response buffer with occupancy count
//   push_i/data_i write an entry, pop_i drops the head (ignored when empty),
//   data_o shows the head entry, count_o is the number of stored entries.
module serial_ram_rsp_fifo #(
  parameter int W = 16,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic [W-1:0]  data_o,
  output logic [CW-1:0] count_o
);
  localparam int PTRW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [W-1:0] mem_q [DEPTH];
  logic [PTRW-1:0] rd_q, wr_q;
  logic [CW-1:0] count_q;
  logic pop;
  function automatic logic [PTRW-1:0] inc(input logic [PTRW-1:0] p);
    return p == PTRW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign pop = pop_i && count_q != '0;
  assign data_o = mem_q[rd_q];
  assign count_o = count_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
    end else begin
      if (push_i) mem_q[wr_q] <= data_i;
      if (push_i) wr_q <= inc(wr_q);
      if (pop) rd_q <= inc(rd_q);
      count_q <= count_q + CW'(push_i) - CW'(pop);
    end
  end
  // a full FIFO may only take a push in the same cycle as a pop
  assert property (@(posedge clk) disable iff (!rst_n) !(push_i && !pop && count_q == CW'(DEPTH)));
endmodule

// File: rtl/serial_ram_reader.sv
// serial_ram_reader: read master serializing addresses onto and deserializing data from the pin-serial RAM
//   req_valid/req_ready/req_addr : read request port
//   rsp_valid/rsp_ready/rsp_data : in-order buffered response port
//   ram_addr_out                 : registered address nibble per frame phase
//   ram_data_in                  : data nibble returned RX_DELAY cycles after frame start
module serial_ram_reader
  import serial_ram_pkg::*;
#(
  parameter int ADDR_PINS = DEF_ADDR_PINS,
  parameter int DATA_PINS = DEF_DATA_PINS,
  parameter int LOG2_CYCLES = DEF_LOG2_CYCLES,
  parameter int RX_DELAY = DEF_RX_DELAY,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int CYCLES = cycles_of(LOG2_CYCLES),
  localparam int ADDR_BITS = ADDR_PINS * CYCLES,
  localparam int DATA_BITS = DATA_PINS * CYCLES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_BITS-1:0] req_addr,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_BITS-1:0] rsp_data,
  output logic [ADDR_PINS-1:0] ram_addr_out,
  input  logic [DATA_PINS-1:0] ram_data_in
);
  localparam int PW = phase_w(LOG2_CYCLES);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  if (!rx_delay_ok(RX_DELAY, CYCLES)) begin : g_bad_rx_delay
    $error("RX_DELAY must be at least CYCLES+1");
  end
  logic [PW-1:0] phase_q, phase_d, cap_idx_q, cap_idx_d;
  logic pend_q, pend_d, cap_on_q, cap_on_d;
  logic [ADDR_BITS-1:0] pend_addr_q, pend_addr_d, frame_addr_q, frame_addr_d;
  logic [ADDR_PINS-1:0] ram_addr_q, ram_addr_d;
  logic [RX_DELAY-1:0] fl_q, fl_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d, word;
  logic last, hs, launch, start, cap_end;
  logic [CW-1:0] fifo_count;
  logic [7:0] outstanding;
  // every accepted read not yet handed to the consumer holds one credit
  assign outstanding = 8'(pend_q) + 8'($countones(fl_q)) + 8'(cap_on_q) + 8'(fifo_count);
  assign req_ready = !pend_q && outstanding < 8'(FIFO_DEPTH);
  assign rsp_valid = fifo_count != '0;
  assign ram_addr_out = ram_addr_q;
  always_comb begin
    last = phase_q == PW'(CYCLES - 1);
    hs = req_valid && req_ready;
    launch = last && (pend_q || hs);
    phase_d = last ? '0 : phase_q + 1'b1;
    frame_addr_d = !launch ? frame_addr_q : pend_q ? pend_addr_q : req_addr;
    ram_addr_d = frame_addr_d[ADDR_PINS*int'(phase_d) +: ADDR_PINS];
    pend_d = !last && (pend_q || hs);
    pend_addr_d = hs && !last ? req_addr : pend_addr_q;
    fl_d = {fl_q[RX_DELAY-2:0], launch};
    // the delay line tail marks the cycle before the first data nibble; a new window may
    // open on the same edge that closes the previous one
    start = fl_q[RX_DELAY-1];
    cap_end = cap_on_q && cap_idx_q == PW'(CYCLES - 1);
    cap_on_d = start || (cap_on_q && !cap_end);
    cap_idx_d = start ? '0 : cap_idx_q + PW'(cap_on_q);
    word = {ram_data_in, shreg_q[DATA_BITS-1:DATA_PINS]};
    shreg_d = cap_on_q ? word : shreg_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
      pend_q <= 1'b0;
      pend_addr_q <= '0;
      frame_addr_q <= '0;
      ram_addr_q <= '0;
      fl_q <= '0;
      cap_on_q <= 1'b0;
      cap_idx_q <= '0;
      shreg_q <= '0;
    end else begin
      phase_q <= phase_d;
      pend_q <= pend_d;
      pend_addr_q <= pend_addr_d;
      frame_addr_q <= frame_addr_d;
      ram_addr_q <= ram_addr_d;
      fl_q <= fl_d;
      cap_on_q <= cap_on_d;
      cap_idx_q <= cap_idx_d;
      shreg_q <= shreg_d;
    end
  end
  serial_ram_rsp_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push_i(cap_end),
    .data_i(word),
    .pop_i(rsp_valid && rsp_ready),
    .data_o(rsp_data),
    .count_o(fifo_count)
  );
endmodule

// File: tb/tb_serial_ram_reader.sv
// tb_serial_ram_reader: directed and random checks of the serial RAM reader against a pin-level RAM model and a response scoreboard
module tb_serial_ram_reader;
  logic clk = 1'b0;
  logic rst_n, req_valid, req_ready, rsp_valid, rsp_ready;
  logic [15:0] req_addr, rsp_data;
  logic [3:0] ram_addr_out, ram_data_in;
  int k = 0, passes = 0, total = 0, rsp_cnt = 0, acc, s;
  logic [15:0] exp_q [$];
  int rsp_cyc [$];

  serial_ram_reader dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .ram_addr_out(ram_addr_out), .ram_data_in(ram_data_in)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ram_mem(input logic [15:0] a);
    return a == 16'h1234 ? 16'hBEEF : 16'(a * 16'd40503 + 16'd13);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // RAM: collects one address nibble per frame phase, answers nibble i in cycle S+12+i
  int mc;
  logic [15:0] ma;
  logic [3:0] sched [32];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mc = 0;
      ma = '0;
      for (int i = 0; i < 32; i++) sched[i] = '0;
      ram_data_in <= '0;
    end else begin
      ma[4*(mc%4) +: 4] = ram_addr_out;
      if (mc % 4 == 3)
        for (int i = 0; i < 4; i++) sched[(mc+9+i)%32] = 4'(ram_mem(ma) >> (4*i));
      mc = mc + 1;
      ram_data_in <= sched[mc%32];
    end
  end

  // scoreboard: every accepted request owes one response, in acceptance order
  always @(negedge clk) begin
    if (rst_n) begin
      if (req_valid && req_ready) begin
        exp_q.push_back(ram_mem(req_addr));
        chk("credit_cap", 32'(exp_q.size() <= 4), 1);
      end
      if (rsp_valid && rsp_ready) begin
        logic [15:0] e;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        else e = 'x;
        chk("rsp_data_order", 32'(rsp_data), 32'(e));
        rsp_cnt++;
        rsp_cyc.push_back(k);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic wait_phase(input int p);
    while (k % 4 != p) tick();
  endtask

  task automatic send(input logic [15:0] a);
    int n = 0;
    req_addr = a;
    req_valid = 1'b1;
    while (!req_ready && n < 40) begin
      tick();
      n++;
    end
    chk("send_ready", 32'(req_ready), 1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic check_frame(input int st, input logic [15:0] a);
    for (int j = 0; j < 4; j++) begin
      while (k < st + j) tick();
      chk("frame_nibble", 32'(ram_addr_out), 32'((a >> (4*j)) & 16'hF));
    end
  endtask

  task automatic wait_rsp(input int t, input logic [15:0] e);
    while (k < t - 1) tick();
    chk("rsp_not_early", 32'(rsp_valid), 0);
    tick();
    chk("rsp_valid_on_time", 32'(rsp_valid), 1);
    chk("rsp_data_value", 32'(rsp_data), 32'(e));
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_addr = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    k = 0;
    for (int i = 0; i < 20; i++) begin
      chk("idle_outputs", 32'({ram_addr_out, req_ready, rsp_valid, rsp_data}), 32'({4'h0, 1'b1, 1'b0, 16'h0}));
      tick();
    end
    wait_phase(1);
    s = k + 3;
    send(16'h1234);
    check_frame(s, 16'h1234);
    wait_rsp(s + 16, 16'hBEEF);
    tick();
    rsp_cyc.delete();
    rsp_cnt = 0;
    for (int i = 0; i < 4; i++) send(16'(i));
    repeat (40) tick();
    chk("b2b_count", 32'(rsp_cnt), 4);
    for (int i = 1; i < 4; i++)
      chk("b2b_spacing", 32'(rsp_cyc.size() > i ? rsp_cyc[i] - rsp_cyc[i-1] : 0), 4);
    rsp_ready = 1'b0;
    acc = 0;
    req_valid = 1'b1;
    req_addr = 16'h0100;
    for (int i = 0; i < 48; i++) begin
      if (req_ready) acc++;
      tick();
      req_addr = 16'h0100 + 16'(acc);
    end
    req_valid = 1'b0;
    chk("full_accepted", 32'(acc), 4);
    chk("full_ready_low", 32'(req_ready), 0);
    chk("full_rsp_valid", 32'(rsp_valid), 1);
    rsp_cnt = 0;
    rsp_ready = 1'b1;
    repeat (6) tick();
    chk("drain_count", 32'(rsp_cnt), 4);
    chk("drain_ready_back", 32'(req_ready), 1);
    wait_phase(3);
    req_addr = 16'hA5C3;
    req_valid = 1'b1;
    chk("bypass_ready", 32'(req_ready), 1);
    tick();
    req_valid = 1'b0;
    s = k;
    check_frame(s, 16'hA5C3);
    wait_rsp(s + 16, ram_mem(16'hA5C3));
    tick();
    send(16'h0010);
    send(16'h0011);
    repeat (6) tick();
    chk("inflight_before_reset", 32'(exp_q.size()), 2);
    rst_n = 1'b0;
    #1;
    chk("reset_outputs", 32'({ram_addr_out, req_ready, rsp_valid, rsp_data}), 32'({4'h0, 1'b1, 1'b0, 16'h0}));
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    k = 0;
    for (int i = 0; i < 24; i++) begin
      chk("no_stale_rsp", 32'(rsp_valid), 0);
      tick();
    end
    wait_phase(1);
    s = k + 3;
    send(16'h1234);
    check_frame(s, 16'h1234);
    wait_rsp(s + 16, 16'hBEEF);
    for (int i = 0; i < 300; i++) begin
      req_valid = 1'($urandom % 2);
      req_addr = 16'($urandom);
      rsp_ready = ($urandom % 4) != 0;
      tick();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (40) tick();
    chk("random_all_returned", 32'(exp_q.size()), 0);
    chk("random_ready_idle", 32'(req_ready), 1);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
